// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM-to-WB pipeline register with load formatting and a valid/ready handshake.
// Define MEM_WB_SKID_EN for a two-entry (main + skid) build with a registered in_ready.
module mem_wb_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        flush,
   input  logic [31:0] pc,
   input  logic [31:0] Ex_result,
   input  logic [31:0] csrs,
   input  logic [31:0] MEM_Rdata,
   input  logic [4:0]  rd,
   input  logic [2:0]  funct3,
   input  logic [3:0]  csr_wen,
   input  logic        R_wen,
   input  logic        mem_ren,
   input  logic        jump_flag,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_data,
   output logic [31:0] wb_csrs,
   output logic [4:0]  wb_rd,
   output logic [3:0]  wb_csr_wen,
   output logic        wb_R_wen,
   output logic        wb_jump_flag
);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
      logic [31:0] csrs;
      logic [4:0]  rd;
      logic [3:0]  csr_wen;
      logic        r_wen;
      logic        jump_flag;
   } wb_entry_t;

   wb_entry_t   in_entry;
   wb_entry_t   main_q;
   logic        main_valid;
   logic        accept;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] load_data;

   // Little-endian lane select from the low address bits, then extension by funct3
   always_comb begin
      load_byte = 8'h00;
      load_half = 16'h0000;
      load_data = MEM_Rdata;
      case (Ex_result[1:0])
         2'd0:    load_byte = MEM_Rdata[7:0];
         2'd1:    load_byte = MEM_Rdata[15:8];
         2'd2:    load_byte = MEM_Rdata[23:16];
         default: load_byte = MEM_Rdata[31:24];
      endcase
      load_half = Ex_result[1] ? MEM_Rdata[31:16] : MEM_Rdata[15:0];
      case (funct3)
         3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_data = {24'h000000, load_byte};
         3'b001:  load_data = {{16{load_half[15]}}, load_half};
         3'b101:  load_data = {16'h0000, load_half};
         default: load_data = MEM_Rdata;
      endcase
   end

   always_comb begin
      in_entry           = '0;
      in_entry.pc        = pc;
      in_entry.data      = mem_ren ? load_data : Ex_result;
      in_entry.csrs      = csrs;
      in_entry.rd        = rd;
      in_entry.csr_wen   = csr_wen;
      in_entry.r_wen     = R_wen;
      in_entry.jump_flag = jump_flag;
   end

   assign accept = in_valid & in_ready & ~flush;

`ifdef MEM_WB_SKID_EN
   wb_entry_t skid_q;
   logic      skid_valid;
   logic      skid_valid_next;
   logic      main_load;

   // Main slot frees up when empty or being consumed; skid only fills on a stalled accept
   assign main_load = ~main_valid | out_ready;

   always_comb begin
      skid_valid_next = skid_valid;
      if (flush) begin
         skid_valid_next = 1'b0;
      end else if (main_load) begin
         skid_valid_next = 1'b0;
      end else if (accept) begin
         skid_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_q     <= '0;
         skid_valid <= 1'b0;
         skid_q     <= '0;
         in_ready   <= 1'b0;
      end else begin
         skid_valid <= skid_valid_next;
         in_ready   <= ~skid_valid_next;
         if (flush) begin
            main_valid <= 1'b0;
         end else if (main_load) begin
            if (skid_valid) begin
               main_q     <= skid_q;
               main_valid <= 1'b1;
            end else if (accept) begin
               main_q     <= in_entry;
               main_valid <= 1'b1;
            end else begin
               main_valid <= 1'b0;
            end
         end
         if (!flush && !main_load && accept) begin
            skid_q <= in_entry;
         end
      end
   end
`else
   logic consume;

   assign in_ready = ~main_valid | out_ready;
   assign consume  = main_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
      end else if (accept) begin
         main_valid <= 1'b1;
         main_q     <= in_entry;
      end else if (consume) begin
         main_valid <= 1'b0;
      end
   end
`endif

   // Write enables are qualified by valid so a bubble or flushed slot never writes
   assign out_valid    = main_valid;
   assign wb_pc        = main_q.pc;
   assign wb_data      = main_q.data;
   assign wb_csrs      = main_q.csrs;
   assign wb_rd        = main_q.rd;
   assign wb_jump_flag = main_q.jump_flag;
   assign wb_R_wen     = main_valid & main_q.r_wen & (main_q.rd != 5'd0);
   assign wb_csr_wen   = main_valid ? main_q.csr_wen : 4'h0;

endmodule

// File: doc/mem_wb_reg.md
# mem_wb_reg

MEM-to-WB pipeline register of the NPC core. Captures the MEM-stage outputs for one instruction per handshake, formats raw load data (byte/halfword extraction, sign/zero extension) and presents a single write-back value, destination and CSR write information to the WB stage and register file. It decouples MEM from WB with a valid/ready handshake and an optional skid buffer.

## Interface
- No parameters; data path fixed at 32 bits.
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  block can accept this cycle.
- flush  in  1  synchronous kill of all held and incoming instructions.
- pc, Ex_result, csrs, MEM_Rdata  in  32  MEM-stage pc, ALU result / load address, CSR value, raw 32-bit word read at Ex_result[31:2].
- rd  in  5, funct3  in  3, csr_wen  in  4, R_wen / mem_ren / jump_flag  in  1 each.
- out_valid  out  1  WB stage holds a valid instruction.
- out_ready  in  1  WB stage consumes this cycle.
- wb_pc, wb_data, wb_csrs  out  32  pc, write-back value, CSR value.
- wb_rd  out  5, wb_csr_wen  out  4, wb_R_wen  out  1, wb_jump_flag  out  1.

## Operation
- Transfer in: in_valid & in_ready & ~flush. Transfer out: out_valid & out_ready.
- Load formatting (mem_ren=1), offset = Ex_result[1:0]:
  - 000 LB: byte at lane offset, sign-extended; 100 LBU: zero-extended.
  - 001 LH: halfword at Ex_result[1] (bit 0 ignored), sign-extended; 101 LHU: zero-extended.
  - 010 LW and all other codes: full MEM_Rdata.
- wb_data = mem_ren ? formatted load : Ex_result; computed before capture, stored registered.
- wb_R_wen = out_valid & R_wen & (rd != 0); wb_csr_wen = out_valid ? csr_wen : 0. Both zero when out_valid=0.
- wb_pc, wb_rd, wb_csrs, wb_jump_flag are registered copies; hold value while out_valid & ~out_ready.
- flush: clears out_valid and any skid entry next edge; an input arriving in the flush cycle is discarded.

## Timing
- Reset: out_valid=0, all wb_* outputs 0; in_ready=1 one cycle after rst_n deasserts (combinationally 1 in pass-through mode).
- Latency: 1 cycle; instruction accepted at edge N appears on outputs after edge N.
- Throughput: one instruction per cycle with out_ready held high.
- Stall: out_ready=0 with out_valid=1 freezes outputs; no instruction lost or duplicated.
- Simultaneous accept and consume on same edge: new instruction replaces old, out_valid stays 1.
- Reset asserted mid-operation: all state cleared immediately, outputs return to reset values asynchronously.

## Configuration
- MEM_WB_SKID_EN defined: two entries (main + skid). in_ready is a register = skid empty; on a stall the beat accepted that cycle lands in skid, and skid drains into main on the next out transfer. No combinational path out_ready -> in_ready.
- Undefined: single entry; in_ready = ~out_valid | out_ready (combinational). Identical data behaviour.

## Test plan
- Reset: hold rst_n=0 mid-stream -> out_valid=0, wb_data=0, wb_R_wen=0; after release first accepted instruction appears one cycle later.
- Loads: MEM_Rdata=0x80F17F22, Ex_result=...03, funct3=000 -> wb_data=0xFFFFFF80; 100 -> 0x00000080; Ex_result=...02, 001 -> 0xFFFF80F1; 101 -> 0x000080F1; 010 -> 0x80F17F22.
- Non-load: mem_ren=0, Ex_result=0x12345678, R_wen=1, rd=5 -> wb_data=0x12345678, wb_R_wen=1; same with rd=0 -> wb_R_wen=0.
- Backpressure: stream A,B,C with out_ready=0 for 3 cycles -> outputs frozen on A, no loss; order A,B,C after release (skid variant: in_ready drops after B accepted).
- Flush: flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, wb_csr_wen=0, incoming instruction never appears.
- Back-to-back: out_ready=1, 8 consecutive instructions -> 8 outputs on 8 consecutive cycles, pc sequence preserved.
